// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: one registered one-hot grant at a time, held for up to the
// winner's weight in completed transactions (done_i), then passed on in rotating order.
module wrr_burst_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WEIGHT_W = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   weight_i,
    input  logic                          done_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id_o,
    output logic                          busy_o
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [IdW-1:0]      last_ptr_q;
    logic [IdW-1:0]      gnt_id_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                busy_q;
    logic [WEIGHT_W-1:0] credit_q;

    logic [IdW-1:0]      search_base;
    logic [IdW-1:0]      win;
    logic [IdW-1:0]      idx_n;
    logic                found;
    logic [WEIGHT_W-1:0] win_weight;
    int unsigned         idx;

    // While granting, selection only matters on release, where last_ptr becomes the grantee,
    // so the current grantee is used as the search base directly.
    always_comb begin
        search_base = (state_q == StGrant) ? gnt_id_q : last_ptr_q;
        found       = 1'b0;
        win         = '0;
        idx         = 0;
        idx_n       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx   = (32'(search_base) + i) % NUM_REQ;
            idx_n = IdW'(idx);
            if (!found && req_i[idx_n]) begin
                found = 1'b1;
                win   = idx_n;
            end
        end
        win_weight = weight_i[win*WEIGHT_W +: WEIGHT_W];
        if (win_weight == '0) begin
            win_weight = WEIGHT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            last_ptr_q <= IdW'(NUM_REQ - 1);
            gnt_id_q   <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            credit_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q  <= StGrant;
                        gnt_q    <= NUM_REQ'(1) << win;
                        gnt_id_q <= win;
                        busy_q   <= 1'b1;
                        credit_q <= win_weight;
                    end
                end
                StGrant: begin
                    if (done_i) begin
                        if (credit_q > WEIGHT_W'(1) && req_i[gnt_id_q]) begin
                            credit_q <= credit_q - WEIGHT_W'(1);
                        end else begin
                            last_ptr_q <= gnt_id_q;
                            if (found) begin
                                gnt_q    <= NUM_REQ'(1) << win;
                                gnt_id_q <= win;
                                credit_q <= win_weight;
                            end else begin
                                state_q  <= StIdle;
                                gnt_q    <= '0;
                                gnt_id_q <= '0;
                                busy_q   <= 1'b0;
                                credit_q <= '0;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: directed vector table, async-reset sequence, then random
// stimulus against a transaction-level reference model.
module tb_wrr_burst_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*WW-1:0] weight;
    logic          done;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    wrr_burst_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .weight_i (weight),
        .done_i   (done),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rst_before;
        logic [3:0]   req;
        logic [15:0]  wt;
        logic         done;
        logic [3:0]   exp_gnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] id_of(input logic [3:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return 0;
    endfunction

    task automatic check_outputs(input string name, input logic [3:0] exp_gnt);
        check({name, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check({name, ".id"}, 32'(gnt_id), id_of(exp_gnt));
        check({name, ".busy"}, 32'(busy), 32'(exp_gnt != 4'b0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset", 4'b0000);
        reset = 1'b0;
    endtask

    task automatic add(input bit r, input logic [3:0] q, input logic [15:0] w, input logic d,
                       input logic [3:0] g);
        vec_t v;
        v.rst_before = r;
        v.req        = q;
        v.wt         = w;
        v.done       = d;
        v.exp_gnt    = g;
        vecs.push_back(v);
    endtask

    // Reference model: which requester holds the resource and how many turns it has left.
    int m_cur;
    int m_last;
    int m_credit;

    function automatic int weight_of(input int k);
        int w;
        w = int'(weight[k*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int pick(input int base);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (base + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (m_cur < 0) begin
            w = pick(m_last);
            if (w >= 0) begin
                m_cur    = w;
                m_credit = weight_of(w);
            end
        end else if (done) begin
            if (m_credit > 1 && req[m_cur]) begin
                m_credit--;
            end else begin
                m_last = m_cur;
                w      = pick(m_last);
                m_cur  = w;
                if (w >= 0) m_credit = weight_of(w);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        req    = '0;
        weight = '0;
        done   = 1'b0;

        // Full rotation, weights 1, done every second cycle
        add(1, 4'b1111, 16'h1111, 0, 4'b0001);
        add(0, 4'b1111, 16'h1111, 1, 4'b0010);
        add(0, 4'b1111, 16'h1111, 0, 4'b0010);
        add(0, 4'b1111, 16'h1111, 1, 4'b0100);
        add(0, 4'b1111, 16'h1111, 0, 4'b0100);
        add(0, 4'b1111, 16'h1111, 1, 4'b1000);
        add(0, 4'b1111, 16'h1111, 0, 4'b1000);
        add(0, 4'b1111, 16'h1111, 1, 4'b0001);
        // w0=2, w1=3, done every cycle (first done lands while idle)
        add(1, 4'b0011, 16'h1132, 1, 4'b0001);
        add(0, 4'b0011, 16'h1132, 1, 4'b0001);
        add(0, 4'b0011, 16'h1132, 1, 4'b0010);
        add(0, 4'b0011, 16'h1132, 1, 4'b0010);
        add(0, 4'b0011, 16'h1132, 1, 4'b0010);
        add(0, 4'b0011, 16'h1132, 1, 4'b0001);
        add(0, 4'b0011, 16'h1132, 1, 4'b0001);
        add(0, 4'b0011, 16'h1132, 1, 4'b0010);
        add(0, 4'b0011, 16'h1132, 1, 4'b0010);
        add(0, 4'b0011, 16'h1132, 1, 4'b0010);
        // Sole requester re-granted after each exhausted turn
        add(1, 4'b0100, 16'h0100, 0, 4'b0100);
        add(0, 4'b0100, 16'h0100, 1, 4'b0100);
        add(0, 4'b0100, 16'h0100, 1, 4'b0100);
        add(0, 4'b0100, 16'h0100, 1, 4'b0100);
        // Early drop: grant held until done, then idle; then drop with a waiter
        add(1, 4'b0010, 16'h0040, 0, 4'b0010);
        add(0, 4'b0010, 16'h0040, 1, 4'b0010);
        add(0, 4'b0000, 16'h0040, 0, 4'b0010);
        add(0, 4'b0000, 16'h0040, 1, 4'b0000);
        add(0, 4'b0010, 16'h0040, 0, 4'b0010);
        add(0, 4'b1000, 16'h0040, 1, 4'b1000);
        // Weight 0 on requester 2 acts as 1
        add(1, 4'b0101, 16'h0001, 1, 4'b0001);
        add(0, 4'b0101, 16'h0001, 1, 4'b0100);
        add(0, 4'b0101, 16'h0001, 1, 4'b0001);
        add(0, 4'b0101, 16'h0001, 1, 4'b0100);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            req    = vecs[i].req;
            weight = vecs[i].wt;
            done   = vecs[i].done;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_gnt);
        end

        // Async reset mid-grant, then requester 0 wins first
        do_reset();
        req    = 4'b1000;
        weight = 16'h1111;
        done   = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("pre_async", 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_clear", 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b1001;
        @(posedge clk);
        #1;
        check_outputs("post_async", 4'b0001);

        // Randomized run against the reference model
        do_reset();
        m_cur    = -1;
        m_last   = N - 1;
        m_credit = 0;
        weight   = 16'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
            done = ($urandom_range(0, 2) != 0);
            model_step();
            @(posedge clk);
            #1;
            check_outputs($sformatf("rand%0d", c),
                          (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
